// File: rtl/mulmod_1973_seq.sv
// Bit-serial modular multiplier: r = (a*b) mod Q, MSB-first over b, one shift-add per clock.
// Each step's partial sum is reduced by an external combinational reducer on red_din/red_dout.
module mulmod_1973_seq #(
    parameter int unsigned Q  = 1973,
    parameter int unsigned W  = $clog2(Q),
    parameter int unsigned DW = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_r,
    output logic [DW-1:0] red_din,
    input  logic [W-1:0]  red_dout
);

    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        in_ready_d = 1'b0;
        red_din    = '0;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    cnt_d   = CW'(W - 1);
                    state_d = StRun;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            StRun: begin
                // 2*acc + a stays below 2*(Q-1) + 2^W, far inside DW bits.
                red_din = {{(DW-W-1){1'b0}}, acc_q, 1'b0}
                        + {{(DW-W){1'b0}}, (b_q[cnt_q] ? a_q : {W{1'b0}})};
                acc_d   = red_dout;
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d    = StIdle;
                    in_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake outputs come from registers only, never from in_valid/out_ready.
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == StDone);
    assign out_r     = (state_q == StDone) ? acc_q : '0;

endmodule

// File: tb/tb_mulmod_1973_seq.sv
// Self-checking bench for mulmod_1973_seq with a behavioural mod-1973 reducer on red_*;
// results are compared against (a*b) % 1973 computed directly.
module tb_mulmod_1973_seq;

    localparam int unsigned Q  = 1973;
    localparam int unsigned W  = 11;
    localparam int unsigned DW = 21;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_r;
    logic [DW-1:0] red_din;
    logic [W-1:0]  red_dout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign red_dout = W'(red_din % DW'(Q));

    mulmod_1973_seq #(
        .Q  (Q),
        .W  (W),
        .DW (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .red_din   (red_din),
        .red_dout  (red_dout)
    );

    function automatic int unsigned ref_mulmod(input int unsigned a, input int unsigned b);
        return (a * b) % Q;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present operands and return #1 after the accept edge.
    task automatic send(input int unsigned a, input int unsigned b, input string tag);
        int waited;
        in_a     = W'(a);
        in_b     = W'(b);
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check_val({tag, " accept timeout"}, 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; the accept clock counts as clock 1.
    task automatic collect(input int unsigned exp, input int unsigned stall, input string tag);
        int           lat;
        logic         stable;
        logic [W-1:0] held;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, " latency"}, 32'(lat), 32'd12);
        if (!out_valid) return;
        held   = out_r;
        stable = 1'b1;
        for (int i = 0; i < int'(stall); i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_r !== held || in_ready !== 1'b0) stable = 1'b0;
        end
        if (stall > 0) check_val({tag, " stall hold"}, 32'(stable), 32'd1);
        check_val({tag, " result"}, 32'(out_r), 32'(exp));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, " post valid"}, 32'(out_valid), 32'd0);
        check_val({tag, " post ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic         stable;
        logic [W-1:0] held;
        int           lat;
        int unsigned  a, b, stall;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_val("rst in_ready", 32'(in_ready), 32'd0);
        check_val("rst out_valid", 32'(out_valid), 32'd0);
        check_val("rst out_r", 32'(out_r), 32'd0);
        check_val("rst red_din", 32'(red_din), 32'd0);
        @(posedge clk);
        #1;
        check_val("rst in_ready after edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("in_ready after release", 32'(in_ready), 32'd1);

        // Directed vectors
        send(1234, 567, "v1234x567");   collect(1236, 0, "v1234x567");
        send(1972, 1972, "v1972sq");    collect(1, 0, "v1972sq");
        send(2047, 2047, "v2047sq");    collect(1530, 0, "v2047sq");
        send(0, 2047, "v0x2047");       collect(0, 0, "v0x2047");
        send(2047, 1, "v2047x1");       collect(74, 0, "v2047x1");

        // Backpressure: 20 stalled cycles in DONE with a competing request pending
        send(100, 200, "bp");
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("bp latency", 32'(lat), 32'd12);
        held     = out_r;
        stable   = 1'b1;
        in_a     = W'(7);
        in_b     = W'(9);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_r !== held || in_ready !== 1'b0) stable = 1'b0;
        end
        check_val("bp hold", 32'(stable), 32'd1);
        check_val("bp result", 32'(held), 32'(ref_mulmod(100, 200)));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("bp in_ready next", 32'(in_ready), 32'd1);
        check_val("bp valid cleared", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        collect(63, 0, "bp second");

        // Asynchronous reset in RUN cycle 5, mid-clock
        send(2047, 2047, "rst mid");
        repeat (4) @(posedge clk);
        #3;
        check_val("mid run red_din active", 32'(red_din != 0), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid rst in_ready", 32'(in_ready), 32'd0);
        check_val("mid rst out_valid", 32'(out_valid), 32'd0);
        check_val("mid rst out_r", 32'(out_r), 32'd0);
        check_val("mid rst red_din", 32'(red_din), 32'd0);
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) stable = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) stable = 1'b0;
        end
        check_val("no valid after rst", 32'(stable), 32'd1);
        send(3, 5, "post rst");
        collect(15, 0, "post rst");

        // Sweeps
        for (int i = 0; i < 2048; i++) begin
            send(i, 1, "sweep a");
            collect(ref_mulmod(i, 1), 0, "sweep a");
        end
        for (int i = 0; i < 2048; i++) begin
            send(1, i, "sweep b");
            collect(ref_mulmod(1, i), 0, "sweep b");
        end

        // Random back-to-back with random stalls
        for (int i = 0; i < 1000; i++) begin
            a     = $urandom_range(0, 2047);
            b     = $urandom_range(0, 2047);
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            send(a, b, "rand");
            collect(ref_mulmod(a, b), stall, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
